// File: rtl/kbd_cmd_ctl.sv
// kbd_cmd_ctl: PS/2 keyboard command controller (reset/BAT handshake, LED updates, response filtering).
// Optional build macro KBD_AUTO_INIT_EN: run the init sequence automatically on leaving reset.
module kbd_cmd_ctl #(
    parameter int unsigned ACK_TIMEOUT = 1000000,
    parameter int unsigned BAT_TIMEOUT = 50000000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_code,
    input  logic       rx_rdy,
    output logic [7:0] out_code,
    output logic       out_rdy,
    output logic [7:0] tx_data,
    output logic       tx_req,
    input  logic       tx_busy,
    input  logic       init_req,
    input  logic       led_req,
    input  logic [2:0] leds,
    output logic       busy,
    output logic       online,
    output logic       error,
    output logic [2:0] state_dbg
);
    // Handshake: rx_rdy, out_rdy, tx_req, init_req and led_req are single-cycle valid strobes with
    // no back-pressure; tx_busy is the only flow control, and tx_req is issued only while it is low.
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_LED     = 8'hED;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
    localparam logic [7:0] RSP_BAT_ERR = 8'hFC;

    localparam int unsigned T_MAX = (BAT_TIMEOUT > ACK_TIMEOUT) ? BAT_TIMEOUT : ACK_TIMEOUT;
    localparam int TW = $clog2(T_MAX + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_RSP, WAIT_BAT, FAIL} state_t;

`ifdef KBD_AUTO_INIT_EN
    localparam state_t RESET_STATE = SEND;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t          state;
    logic            seq_init;
    logic            byte_idx;
    logic [2:0]      led_q;
    logic [RW-1:0]   retry_cnt;
    logic [TW-1:0]   timer;
    logic            seen_busy;

    logic            swallow;
    logic            pass;
    logic            rx_ack;
    logic            rx_resend;
    logic            timed_out;
    logic            retry_exhausted;
    logic [7:0]      cur_byte;

    always_comb begin
        swallow         = 1'b0;
        rx_ack          = rx_rdy && (rx_code == RSP_ACK);
        rx_resend       = rx_rdy && (rx_code == RSP_RESEND);
        // A received byte in the expiry cycle wins over the timeout.
        timed_out       = !rx_rdy && (timer == '0);
        retry_exhausted = retry_cnt >= RW'(MAX_RETRY);
        cur_byte        = seq_init ? CMD_RESET : (byte_idx ? {5'b0, led_q} : CMD_LED);
        case (state)
            WAIT_RSP: swallow = (rx_code == RSP_ACK) || (rx_code == RSP_RESEND);
            WAIT_BAT: swallow = (rx_code == RSP_ACK) || (rx_code == RSP_RESEND) ||
                                (rx_code == RSP_BAT_OK) || (rx_code == RSP_BAT_ERR);
            default:  swallow = 1'b0;
        endcase
        pass = rx_rdy && !swallow;
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RESET_STATE;
            out_code  <= 8'h00;
            out_rdy   <= 1'b0;
            tx_data   <= 8'h00;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            online    <= 1'b0;
            error     <= 1'b0;
            seq_init  <= 1'b1;
            byte_idx  <= 1'b0;
            led_q     <= 3'b000;
            retry_cnt <= '0;
            timer     <= '0;
            seen_busy <= 1'b0;
        end else begin
            tx_req  <= 1'b0;
            out_rdy <= pass;
            if (pass) out_code <= rx_code;

            case (state)
                IDLE: begin
                    if (init_req) begin
                        seq_init  <= 1'b1;
                        byte_idx  <= 1'b0;
                        retry_cnt <= '0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end else if (led_req && online) begin
                        seq_init  <= 1'b0;
                        byte_idx  <= 1'b0;
                        retry_cnt <= '0;
                        led_q     <= leds;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end else if (rx_rdy && (rx_code == RSP_BAT_OK) && !online) begin
                        // Unsolicited BAT after a hot-plug marks the keyboard present.
                        online <= 1'b1;
                    end
                end
                SEND: begin
                    busy <= 1'b1;
                    if (!tx_busy) begin
                        tx_req    <= 1'b1;
                        tx_data   <= cur_byte;
                        seen_busy <= 1'b0;
                        state     <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (tx_busy) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        timer <= TW'(ACK_TIMEOUT);
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rx_ack) begin
                        retry_cnt <= '0;
                        if (seq_init) begin
                            timer <= TW'(BAT_TIMEOUT);
                            state <= WAIT_BAT;
                        end else if (!byte_idx) begin
                            byte_idx <= 1'b1;
                            state    <= SEND;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (rx_resend || timed_out) begin
                        if (retry_exhausted) begin
                            state <= FAIL;
                        end else begin
                            retry_cnt <= retry_cnt + RW'(1);
                            state     <= SEND;
                        end
                    end else if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end
                end
                WAIT_BAT: begin
                    if (rx_rdy && (rx_code == RSP_BAT_OK)) begin
                        online <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if ((rx_rdy && (rx_code == RSP_BAT_ERR)) || timed_out) begin
                        online <= 1'b0;
                        state  <= FAIL;
                    end else if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end
                end
                FAIL: begin
                    error  <= 1'b1;
                    online <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kbd_cmd_ctl.sv
// Randomized scoreboard bench for kbd_cmd_ctl: a transmitter/keyboard model replies to commands,
// while a negedge monitor checks tx bytes and pass-through bytes (value and 1-cycle latency).
module tb_kbd_cmd_ctl;
    localparam int ACK_TO    = 100;
    localparam int BAT_TO    = 2000;
    localparam int MAX_RETRY = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_code = 8'h00;
    logic       rx_rdy = 1'b0;
    logic [7:0] out_code;
    logic       out_rdy;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_busy = 1'b0;
    logic       init_req = 1'b0;
    logic       led_req = 1'b0;
    logic [2:0] leds = 3'b000;
    logic       busy;
    logic       online;
    logic       error;
    logic [2:0] state_dbg;

    kbd_cmd_ctl #(
        .ACK_TIMEOUT(ACK_TO),
        .BAT_TIMEOUT(BAT_TO),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .rx_code  (rx_code),
        .rx_rdy   (rx_rdy),
        .out_code (out_code),
        .out_rdy  (out_rdy),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .tx_busy  (tx_busy),
        .init_req (init_req),
        .led_req  (led_req),
        .leds     (leds),
        .busy     (busy),
        .online   (online),
        .error    (error),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];     // {expected out_rdy cycle, pass-through byte}
    logic [7:0]  exp_tx_q[$];  // bytes expected on tx_data, in order

    bit m_online = 1'b0;
    bit m_error  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string act, input string req);
        checks++;
        errors++;
        $display("FAIL %s actual=%s required=%s", name, act, req);
    endtask

    // Transmitter model + monitor: busy for a random few cycles per byte.
    int tx_left  = 0;
    int done_cnt = 0;
    int done_seen = 0;
    always @(negedge clk) begin : mon
        logic [39:0] e;
        if (out_rdy) begin
            if (exp_q.size() == 0) begin
                fail_now("out_unexpected", $sformatf("%0h", out_code), "none");
            end else begin
                e = exp_q.pop_front();
                check("out_code", {24'h0, out_code}, {24'h0, e[7:0]});
                check("out_cycle", cyc, e[39:8]);
            end
        end
        if (!rst_n) begin
            tx_busy = 1'b0;
            tx_left = 0;
        end else if (tx_req) begin
            check("tx_req_while_busy", {31'h0, tx_busy}, 32'h0);
            if (exp_tx_q.size() == 0)
                fail_now("tx_unexpected", $sformatf("%0h", tx_data), "none");
            else
                check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
            tx_busy = 1'b1;
            tx_left = $urandom_range(2, 6);
        end else if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) begin
                tx_busy = 1'b0;
                done_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit pass);
        @(negedge clk);
        rx_code = b;
        rx_rdy  = 1'b1;
        if (pass) exp_q.push_back({cyc + 32'd1, b});
    endtask

    task automatic rx_done();
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    function automatic logic [7:0] rand_scan();
        return 8'($urandom_range(1, 'h7F));
    endfunction

    task automatic wait_tx_done();
        for (int i = 0; i < 400; i++) begin
            if (done_cnt > done_seen) break;
            @(negedge clk);
            #1;
        end
        if (done_cnt > done_seen) done_seen++;
        else fail_now("tx_done_timeout", "no byte", "byte sent");
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_reached", {31'h0, busy}, 32'h0);
    endtask

    task automatic pulse_init(input bit accept);
        if (accept) done_seen = done_cnt;
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        if (accept) begin
            check("busy_rise_init", {31'h0, busy}, 32'h1);
            m_error = 1'b0;
        end
    endtask

    task automatic pulse_led(input logic [2:0] v, input bit accept);
        if (accept) done_seen = done_cnt;
        @(negedge clk);
        led_req = 1'b1;
        leds    = v;
        @(negedge clk);
        led_req = 1'b0;
        leds    = 3'($urandom_range(0, 7));
        check(accept ? "busy_rise_led" : "busy_led_ignored", {31'h0, busy}, {31'h0, accept});
        if (accept) m_error = 1'b0;
    endtask

    // One command byte: the keyboard answers FE fe_n times, then FA. More than MAX_RETRY
    // resends exhausts the byte and the sequence fails.
    task automatic do_byte(input logic [7:0] b, input int fe_n, input bit pre, output bit failed);
        failed = 1'b0;
        for (int a = 0; a <= MAX_RETRY; a++) begin
            if (a > 0 || !pre) exp_tx_q.push_back(b);
            wait_tx_done();
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) send_rx(rand_scan(), 1'b1);
            if (a < fe_n) begin
                send_rx(8'hFE, 1'b0);
                rx_done();
                if (a + 1 > MAX_RETRY) begin
                    failed = 1'b1;
                    return;
                end
            end else begin
                send_rx(8'hFA, 1'b0);
                rx_done();
                return;
            end
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_online"}, {31'h0, online}, {31'h0, m_online});
        check({tag, "_error"}, {31'h0, error}, {31'h0, m_error});
    endtask

    task automatic init_body(input logic [7:0] bat, input int fe_n, input bit pre);
        bit f;
        do_byte(8'hFF, fe_n, pre, f);
        if (f) begin
            m_error  = 1'b1;
            m_online = 1'b0;
        end else begin
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) send_rx(rand_scan(), 1'b1);
            send_rx(bat, 1'b0);
            rx_done();
            m_online = (bat == 8'hAA);
            if (bat != 8'hAA) m_error = 1'b1;
        end
        wait_idle(2000);
        check_flags("init");
    endtask

    task automatic run_init(input logic [7:0] bat, input int fe_n);
        pulse_init(1'b1);
        init_body(bat, fe_n, 1'b0);
    endtask

    task automatic run_led(input logic [2:0] v, input int k0, input int k1);
        bit f;
        if (!m_online) begin
            pulse_led(v, 1'b0);
            idle(5);
            check("led_offline_busy", {31'h0, busy}, 32'h0);
            return;
        end
        pulse_led(v, 1'b1);
        do_byte(8'hED, k0, 1'b0, f);
        if (!f) do_byte({5'b0, v}, k1, 1'b0, f);
        if (f) begin
            m_error  = 1'b1;
            m_online = 1'b0;
        end
        wait_idle(2000);
        check_flags("led");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_code"}, {24'h0, out_code}, 32'h0);
        check({tag, "_out_rdy"}, {31'h0, out_rdy}, 32'h0);
        check({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
        check({tag, "_tx_req"}, {31'h0, tx_req}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_online"}, {31'h0, online}, 32'h0);
        check({tag, "_error"}, {31'h0, error}, 32'h0);
    endtask

    task automatic release_reset();
`ifdef KBD_AUTO_INIT_EN
        exp_tx_q.push_back(8'hFF);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = done_cnt;
`ifdef KBD_AUTO_INIT_EN
        @(negedge clk);
        check("auto_init_busy", {31'h0, busy}, 32'h1);
        init_body(8'hAA, 0, 1'b1);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        bit f;
        idle(3);
        check_reset_values("rst");
        release_reset();

        // LED request while offline (default build) is ignored.
        run_led(3'b011, 0, 0);

        // Pass-through in IDLE: back-to-back codes, a stray FA, then random bytes.
        send_rx(8'h1C, 1'b1);
        send_rx(8'hF0, 1'b1);
        send_rx(8'h1C, 1'b1);
        send_rx(8'hFA, 1'b1);
        rx_done();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i == 5) b = 8'hAA;
            send_rx(b, 1'b1);
            if (b == 8'hAA) m_online = 1'b1;
        end
        rx_done();
        idle(2);
        check_flags("idle_pass");

        // Explicit init, then the plain LED update with 3'b101.
        run_init(8'hAA, 0);
        run_led(3'b101, 0, 0);
        // Two resends of ED, then success.
        run_led(3'($urandom_range(0, 7)), 2, 0);
        // Resends exhausted on ED.
        run_led(3'($urandom_range(0, 7)), MAX_RETRY + 1, 0);
        run_led(3'b110, 0, 0);

        // Randomized mix of init and LED sequences.
        for (int i = 0; i < 10; i++) begin
            if (!m_online || $urandom_range(0, 3) == 0)
                run_init(($urandom_range(0, 4) == 0) ? 8'hFC : 8'hAA,
                         ($urandom_range(0, 7) == 0) ? MAX_RETRY + 1 : $urandom_range(0, 2));
            else
                run_led(3'($urandom_range(0, 7)),
                        ($urandom_range(0, 7) == 0) ? MAX_RETRY + 1 : $urandom_range(0, 2),
                        $urandom_range(0, 2));
        end

        // Requests while busy are dropped.
        if (!m_online) run_init(8'hAA, 0);
        exp_tx_q.push_back(8'hED);
        pulse_led(3'b010, 1'b1);
        pulse_init(1'b0);
        do_byte(8'hED, 0, 1'b1, f);
        do_byte(8'h02, 0, 1'b0, f);
        wait_idle(2000);
        check_flags("drop");

        // No reply at all: 1 + MAX_RETRY transmissions, then error.
        for (int i = 0; i <= MAX_RETRY; i++) exp_tx_q.push_back(8'hFF);
        pulse_init(1'b1);
        wait_idle((MAX_RETRY + 1) * (ACK_TO + 20) + 50);
        m_error  = 1'b1;
        m_online = 1'b0;
        check_flags("timeout");
        check("timeout_tx_count", exp_tx_q.size(), 32'h0);

        // Reset asserted while waiting for BAT.
        run_init(8'hAA, 0);
        pulse_init(1'b1);
        do_byte(8'hFF, 0, 1'b0, f);
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        m_online = 1'b0;
        m_error  = 1'b0;
        idle(2);
        release_reset();
        idle(5);
        check_flags("post_rst");

        idle(5);
        check("exp_out_empty", exp_q.size(), 32'h0);
        check("exp_tx_empty", exp_tx_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kbd_cmd_ctl.md
# kbd_cmd_ctl

Host-side command controller for the PS/2 keyboard path. It sequences keyboard configuration traffic: a reset/self-test handshake and LED updates. It drives a PS/2 byte transmitter and consumes the keyboard's response bytes (ACK, RESEND, BAT) from the receive stream. All other received scancodes pass through to the scancode converter unchanged, delayed by one register stage.

## Interface
Parameters:
- `ACK_TIMEOUT`, 1000000: cycles to wait for a response byte after a transmitted byte completes.
- `BAT_TIMEOUT`, 50000000: cycles to wait for the BAT byte after the reset ACK.
- `MAX_RETRY`, 3: RESEND/timeout retries allowed per byte before the controller declares an error.

Ports:
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `rx_code` in 8: byte from the PS/2 receiver.
- `rx_rdy` in 1: one-cycle strobe; `rx_code` is valid.
- `out_code` out 8: pass-through byte to the scancode converter.
- `out_rdy` out 1: one-cycle strobe for `out_code`.
- `tx_data` out 8: byte to the PS/2 transmitter.
- `tx_req` out 1: one-cycle request to send `tx_data`.
- `tx_busy` in 1: the transmitter is shifting a byte.
- `init_req` in 1: pulse; requests the reset sequence.
- `led_req` in 1: pulse; requests an LED update.
- `leds` in 3: {caps, num, scroll}; sampled on `led_req`.
- `busy` out 1: a command sequence is in progress.
- `online` out 1: the last reset sequence passed BAT.
- `error` out 1: sticky; cleared by the next accepted request.

## Operation
- States: IDLE, SEND, WAIT_TX, WAIT_RSP, WAIT_BAT, FAIL.
- Sequences:
  - init: FF, then ACK, then BAT.
  - LED: ED, then ACK, then {5'b0, leds}, then ACK.
  - A byte-index register selects the current byte.
- IDLE:
  - `init_req` has priority over `led_req` in the same cycle.
  - `led_req` while `online`=0 is ignored.
  - An accepted request clears `error`, sets `busy`, and enters SEND.
  - The LED value is latched when the request is accepted.
- SEND:
  - Wait for `tx_busy`=0, then pulse `tx_req` for one cycle with `tx_data` valid, then go to WAIT_TX.
- WAIT_TX:
  - Wait for `tx_busy` to rise and fall again, then load the timeout counter with `ACK_TIMEOUT` and go to WAIT_RSP.
- WAIT_RSP, with `rx_rdy` asserted:
  - FA (ACK): advance to the next byte, which goes to SEND. After the init FF, go to WAIT_BAT and load `BAT_TIMEOUT`. After the last LED byte, go to IDLE.
  - FE (RESEND): increment the retry count and go back to SEND with the same byte.
  - Other bytes: pass through; stay in WAIT_RSP.
- Timeout expiry in WAIT_RSP counts as a retry.
- Retry count greater than `MAX_RETRY`: go to FAIL.
- The retry count resets to 0 on each new byte.
- WAIT_BAT:
  - AA: `online`=1, go to IDLE.
  - FC, or timeout: `online`=0, go to FAIL.
  - Other bytes: pass through.
- FAIL: set `error`, clear `online`, go to IDLE on the next cycle.
- Swallowing:
  - FA/FE are consumed only in WAIT_RSP; FA/FE/AA/FC are consumed only in WAIT_BAT.
  - In IDLE, every byte passes through, including a stray FA, and including AA. The keyboard sends AA unsolicited on hot-plug; with `online`=0, an AA seen in IDLE sets `online`.
- The timeout counter is wide enough for `BAT_TIMEOUT` and counts down to 0. Expiry is the cycle the counter reaches 0.

## Timing
- Reset values:
  - `out_code`=0, `out_rdy`=0, `tx_data`=0, `tx_req`=0, `busy`=0, `online`=0, `error`=0.
  - State = IDLE, or SEND with the init sequence when `KBD_AUTO_INIT_EN` is defined.
- Pass-through latency is 1 cycle: `rx_rdy` at cycle N gives `out_rdy` at N+1. Back-to-back strobes are preserved.
- `tx_req` is asserted at most one cycle per byte; it is never asserted while `tx_busy`=1.
- `busy` rises the cycle after request acceptance and falls the cycle the controller enters IDLE.
- Requests arriving while `busy`=1 are dropped; there is no queueing.
- Reset mid-sequence: the controller returns immediately to reset values, and `tx_req` deasserts asynchronously. A transmitter byte already in flight is not tracked.
- An `rx_rdy` in the same cycle as timeout expiry is processed as a received byte; the timeout is ignored.

## Configuration
- `KBD_AUTO_INIT_EN`:
  - Defined: on leaving reset, the controller runs the init sequence automatically, then idles. `busy`=1 from the first clock after reset release.
  - Undefined: the controller stays in IDLE until `init_req`, and `online` becomes 1 only through an explicit init or an unsolicited AA.

## Test plan
- Init: pulse `init_req`; the model replies FA then AA. Required: `tx_data`=FF with one `tx_req` pulse, `online`=1, `busy`=0, `out_rdy` never pulses.
- LED update: `online`=1, `leds`=3'b101, pulse `led_req`; the model ACKs each byte. Required: `tx_req` pulses carrying ED then 05, `error`=0.
- Resend: the model replies FE twice, then FA, to ED. Required: ED is sent 3 times and the sequence completes. With `MAX_RETRY`=1, the same stimulus sets `error`=1 and clears `online`.
- Timeout: `ACK_TIMEOUT`=100 and no reply. Required: 4 transmissions, then `error`=1 within 4×(100+tx) cycles, and the controller returns to IDLE.
- Pass-through: in IDLE, codes 1C, F0, 1C arrive on consecutive cycles. Required: the `out_code` sequence is identical, each delayed 1 cycle. A stray FA in IDLE also passes through. During WAIT_RSP, FA is swallowed while 1C passes.
- Reset assertion during WAIT_BAT: all outputs return to reset values. With `KBD_AUTO_INIT_EN` defined, FF is re-sent after reset release.
